// File: rtl/char_tx_pkg.sv
// Shared constants for the memory-mapped character TX port.
// CHARTX_DROP_CNT_EN selects the compact status layout that carries the drop counter.
package char_tx_pkg;

  localparam logic [31:0] TX_ADDR_DEF     = 32'h0000_0100;
  localparam logic [31:0] STATUS_ADDR_DEF = 32'h0000_0101;

  localparam int CTL_CLR_OVF = 0;
  localparam int CTL_FLUSH   = 1;

  localparam int ST_DROP_LSB = 8;
  localparam int DROP_W      = 8;

`ifdef CHARTX_DROP_CNT_EN
  // Count squeezes into a nibble so the drop counter can own the upper byte.
  localparam int ST_COUNT_W = 4;
  localparam int ST_EMPTY   = 4;
  localparam int ST_FULL    = 5;
  localparam int ST_OVF     = 6;
`else
  localparam int ST_COUNT_W = 8;
  localparam int ST_EMPTY   = 8;
  localparam int ST_FULL    = 9;
  localparam int ST_OVF     = 10;
`endif

  function automatic logic [DROP_W-1:0] satInc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + {{(DROP_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/char_fifo.sv
// First-word-fall-through character FIFO with extra-MSB pointers.
// A full FIFO still accepts a push when the head leaves on the same edge.
module char_fifo #(
  parameter int DEPTH  = 8,
  parameter int CHAR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [CHAR_W-1:0]        data_i,
  output logic [CHAR_W-1:0]        data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [CHAR_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wrPtr_q, wrPtr_d;
  logic [AW:0]       rdPtr_q, rdPtr_d;
  logic              doPush, doPop;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign count_o = wrPtr_q - rdPtr_q;

  assign doPop  = pop_i && !empty_o && !flush_i;
  assign doPush = push_i && (!full_o || doPop);

  // Flush discards everything queued so far by catching the read side up.
  always_comb begin
    wrPtr_d = wrPtr_q + {{AW{1'b0}}, doPush};
    rdPtr_d = flush_i ? wrPtr_q : rdPtr_q + {{AW{1'b0}}, doPop};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q[AW-1:0]] <= data_i;
    end
  end

  // Stale storage is masked so an empty FIFO always presents zero.
  assign data_o = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];

endmodule

// File: rtl/char_tx_port.sv
// Memory-mapped character output port: stores to TX_ADDR queue characters for a
// valid/ready sink; STATUS_ADDR reads status and takes control stores. Macro: CHARTX_DROP_CNT_EN.
module char_tx_port
  import char_tx_pkg::*;
#(
  parameter int          DEPTH       = 8,
  parameter int          CHAR_W      = 16,
  parameter logic [31:0] TX_ADDR     = TX_ADDR_DEF,
  parameter logic [31:0] STATUS_ADDR = STATUS_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic              hit,
  output logic [31:0]       read_data,
  output logic [CHAR_W-1:0] char_out,
  output logic              char_valid,
  input  logic              char_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          txSel, stSel;
  logic          pushReq, ctlWrite, clrOvf, flush, popReq, dropEvt;
  logic          fifoFull, fifoEmpty;
  logic [CW-1:0] fifoCount;
  logic          ovf_q, ovf_d;
  logic [31:0]   status;
  logic          unusedWdata;

  assign txSel = (address == TX_ADDR);
  assign stSel = (address == STATUS_ADDR);
  assign hit   = txSel || stSel;

  assign pushReq  = mem_write && txSel;
  assign ctlWrite = mem_write && stSel;
  assign clrOvf   = ctlWrite && write_data[CTL_CLR_OVF];
  assign flush    = ctlWrite && write_data[CTL_FLUSH];

  assign char_valid = !fifoEmpty;
  assign popReq     = char_valid && char_ready;
  assign dropEvt    = pushReq && fifoFull && !popReq;

  char_fifo #(
    .DEPTH  (DEPTH),
    .CHAR_W (CHAR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pushReq),
    .pop_i   (popReq),
    .flush_i (flush),
    .data_i  (write_data[CHAR_W-1:0]),
    .data_o  (char_out),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (dropEvt) begin
      ovf_d = 1'b1;
    end else if (clrOvf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

`ifdef CHARTX_DROP_CNT_EN
  logic [DROP_W-1:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (dropEvt) begin
      drop_d = satInc(drop_q);
    end else if (clrOvf) begin
      drop_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end
`endif

  // Status is driven only while a load targets it so the MemData mux sees zero otherwise.
  always_comb begin
    status = '0;
    if (mem_read && stSel) begin
      status[ST_COUNT_W-1:0] = ST_COUNT_W'(fifoCount);
      status[ST_EMPTY]       = fifoEmpty;
      status[ST_FULL]        = fifoFull;
      status[ST_OVF]         = ovf_q;
`ifdef CHARTX_DROP_CNT_EN
      status[ST_DROP_LSB +: DROP_W] = drop_q;
`endif
    end
  end

  assign read_data = status;

  assign unusedWdata = ^write_data[31:CHAR_W];

endmodule

// File: tb/tb_char_tx_port.sv
// Randomized self-checking bench for char_tx_port against a queue-based reference model.
// Honours CHARTX_DROP_CNT_EN when it is defined for the build.
module tb_char_tx_port;

  localparam int          DEPTH   = 8;
  localparam logic [31:0] TX      = 32'h0000_0100;
  localparam logic [31:0] STATUS  = 32'h0000_0101;

  logic        clk;
  logic        rst;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        hit;
  logic [31:0] read_data;
  logic [15:0] char_out;
  logic        char_valid;
  logic        char_ready;

  int checks = 0;
  int errors = 0;

  logic [15:0] modelQ[$];
  logic        modelOvf;
  int          modelDrops;
  logic [15:0] rxQ[$];
  logic [15:0] sentQ[$];

  char_tx_port #(.DEPTH(DEPTH), .CHAR_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .address    (address),
    .write_data (write_data),
    .hit        (hit),
    .read_data  (read_data),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Status word the specification promises for the model's current contents.
  function automatic logic [31:0] expStatus();
    logic [31:0] s;
    int n;
    s = '0;
    n = modelQ.size();
`ifdef CHARTX_DROP_CNT_EN
    s[3:0]  = 4'(n);
    s[4]    = (n == 0);
    s[5]    = (n == DEPTH);
    s[6]    = modelOvf;
    s[15:8] = 8'(modelDrops);
`else
    s[7:0]  = 8'(n);
    s[8]    = (n == 0);
    s[9]    = (n == DEPTH);
    s[10]   = modelOvf;
`endif
    return s;
  endfunction

  // One clock of bus/sink activity; the model advances by the specification's rules.
  task automatic step(input logic mw, input logic [31:0] addr, input logic [31:0] wd,
                      input logic rdy, input logic rstn);
    logic pop, full, isFlush;
    mem_write  = mw;
    address    = addr;
    write_data = wd;
    char_ready = rdy;
    rst        = rstn;
    mem_read   = 1'b0;
    #1;
    isFlush = mw && (addr == STATUS) && wd[1];
    pop     = (modelQ.size() != 0) && rdy;
    if (char_valid && char_ready && rstn && !isFlush) rxQ.push_back(char_out);
    @(posedge clk);
    if (!rstn) begin
      modelQ.delete();
      modelOvf   = 1'b0;
      modelDrops = 0;
    end else if (mw && addr == STATUS) begin
      if (wd[0]) begin
        modelOvf   = 1'b0;
        modelDrops = 0;
      end
      if (wd[1]) modelQ.delete();
      else if (pop) void'(modelQ.pop_front());
    end else begin
      full = (modelQ.size() == DEPTH);
      if (pop) void'(modelQ.pop_front());
      if (mw && addr == TX) begin
        if (full && !pop) begin
          modelOvf = 1'b1;
          if (modelDrops < 255) modelDrops++;
        end else begin
          modelQ.push_back(wd[15:0]);
        end
      end
    end
    #1;
    mem_write  = 1'b0;
    address    = '0;
    write_data = '0;
    rst        = 1'b1;
  endtask

  task automatic loadStatus(output logic [31:0] v);
    mem_read = 1'b1;
    address  = STATUS;
    #1;
    v        = read_data;
    mem_read = 1'b0;
    address  = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    logic [31:0] s;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (char_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", char_valid); end
    checks++;
    if (char_out !== 16'h0) begin errors++; $display("[TB] FAIL reset_char_out: got %h expected 0000", char_out); end
    loadStatus(s);
    checks++;
    if (s !== expStatus()) begin errors++; $display("[TB] FAIL reset_status: got %h expected %h", s, expStatus()); end
    address = STATUS;
    #1;
    checks++;
    if (hit !== 1'b1 || read_data !== 32'h0) begin
      errors++; $display("[TB] FAIL status_no_read: got hit=%b data=%h expected hit=1 data=0", hit, read_data);
    end
    address = 32'h0000_0102;
    #1;
    checks++;
    if (hit !== 1'b0) begin errors++; $display("[TB] FAIL hit_other: got %b expected 0", hit); end
    address = '0;
  endtask

  task automatic test_single_push();
    logic [31:0] s;
    step(1'b1, TX, 32'hABCD_0041, 1'b0, 1'b1);
    checks++;
    if (char_valid !== 1'b1 || char_out !== 16'h0041) begin
      errors++; $display("[TB] FAIL single_push: got valid=%b char=%h expected valid=1 char=0041", char_valid, char_out);
    end
    loadStatus(s);
    checks++;
    if (s !== expStatus() || s[7:0] === 8'h00) begin
      errors++; $display("[TB] FAIL single_status: got %h expected %h", s, expStatus());
    end
    drain();
  endtask

  task automatic test_stream();
    logic [15:0] exp[3];
    exp[0] = 16'h0048; exp[1] = 16'h0069; exp[2] = 16'h0021;
    rxQ.delete();
    for (int i = 0; i < 3; i++) step(1'b1, TX, {16'h0, exp[i]}, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (rxQ.size() != 3) begin errors++; $display("[TB] FAIL stream_len: got %0d expected 3", rxQ.size()); end
    for (int i = 0; i < 3 && i < rxQ.size(); i++) begin
      checks++;
      if (rxQ[i] !== exp[i]) begin errors++; $display("[TB] FAIL stream_char%0d: got %h expected %h", i, rxQ[i], exp[i]); end
    end
    checks++;
    if (char_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_empty: got valid=%b expected 0", char_valid); end
  endtask

  task automatic test_overflow();
    logic [31:0] s;
    sentQ.delete();
    rxQ.delete();
    for (int i = 0; i < 9; i++) begin
      sentQ.push_back(16'($urandom));
      step(1'b1, TX, {16'($urandom), sentQ[i]}, 1'b0, 1'b1);
    end
    loadStatus(s);
    checks++;
    if (s !== expStatus()) begin errors++; $display("[TB] FAIL ovf_status: got %h expected %h", s, expStatus()); end
    step(1'b1, STATUS, 32'h1, 1'b0, 1'b1);
    loadStatus(s);
    checks++;
    if (s !== expStatus()) begin errors++; $display("[TB] FAIL ovf_clear: got %h expected %h", s, expStatus()); end
    drain();
    checks++;
    if (rxQ.size() != DEPTH) begin errors++; $display("[TB] FAIL ovf_len: got %0d expected %0d", rxQ.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < rxQ.size(); i++) begin
      checks++;
      if (rxQ[i] !== sentQ[i]) begin errors++; $display("[TB] FAIL ovf_char%0d: got %h expected %h", i, rxQ[i], sentQ[i]); end
    end
  endtask

  task automatic test_full_pushpop();
    logic [31:0] s;
    logic [15:0] last;
    rxQ.delete();
    for (int i = 0; i < DEPTH; i++) step(1'b1, TX, $urandom, 1'b0, 1'b1);
    last = 16'($urandom);
    step(1'b1, TX, {16'h0, last}, 1'b1, 1'b1);
    loadStatus(s);
    checks++;
    if (s !== expStatus()) begin errors++; $display("[TB] FAIL full_pushpop_status: got %h expected %h", s, expStatus()); end
    drain();
    checks++;
    if (rxQ.size() != DEPTH + 1 || rxQ[rxQ.size()-1] !== last) begin
      errors++; $display("[TB] FAIL full_pushpop_last: got len=%0d last=%h expected len=%0d last=%h",
                         rxQ.size(), rxQ[rxQ.size()-1], DEPTH + 1, last);
    end
  endtask

  task automatic test_flush();
    logic [31:0] s;
    for (int i = 0; i < 3; i++) step(1'b1, TX, $urandom, 1'b0, 1'b1);
    step(1'b1, STATUS, 32'h2, 1'b1, 1'b1);
    loadStatus(s);
    checks++;
    if (char_valid !== 1'b0 || s !== expStatus()) begin
      errors++; $display("[TB] FAIL flush: got valid=%b status=%h expected valid=0 status=%h", char_valid, s, expStatus());
    end
    step(1'b1, TX, 32'h0000_005A, 1'b0, 1'b1);
    checks++;
    if (char_valid !== 1'b1 || char_out !== 16'h005A) begin
      errors++; $display("[TB] FAIL flush_repush: got valid=%b char=%h expected valid=1 char=005a", char_valid, char_out);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic [31:0] s;
    step(1'b1, TX, $urandom, 1'b0, 1'b1);
    step(1'b1, TX, $urandom, 1'b1, 1'b0);
    loadStatus(s);
    checks++;
    if (char_valid !== 1'b0 || s !== expStatus()) begin
      errors++; $display("[TB] FAIL reset_mid: got valid=%b status=%h expected valid=0 status=%h", char_valid, s, expStatus());
    end
`ifdef CHARTX_DROP_CNT_EN
    for (int i = 0; i < DEPTH + 260; i++) step(1'b1, TX, $urandom, 1'b0, 1'b1);
    loadStatus(s);
    checks++;
    if (s[15:8] !== 8'hFF || s !== expStatus()) begin
      errors++; $display("[TB] FAIL drop_saturate: got %h expected %h", s, expStatus());
    end
    step(1'b1, STATUS, 32'h1, 1'b0, 1'b1);
    loadStatus(s);
    checks++;
    if (s !== expStatus()) begin errors++; $display("[TB] FAIL drop_clear: got %h expected %h", s, expStatus()); end
    drain();
`endif
  endtask

  task automatic test_random();
    logic [31:0] s;
    int sel;
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 45)      step(1'b1, TX, $urandom, 1'($urandom), 1'b1);
      else if (sel < 50) step(1'b1, STATUS, {30'($urandom), 2'($urandom)}, 1'($urandom), 1'b1);
      else if (sel < 55) step(1'b1, 32'h0000_00FF + 32'($urandom_range(0, 1)) * 3, $urandom, 1'($urandom), 1'b1);
      else               step(1'b0, 32'h0, 32'h0, ($urandom_range(0, 2) == 0), 1'b1);
      checks++;
      if (char_valid !== (modelQ.size() != 0)) begin
        errors++; $display("[TB] FAIL rand_valid@%0d: got %b expected %b", i, char_valid, modelQ.size() != 0);
      end else if (modelQ.size() != 0 && char_out !== modelQ[0]) begin
        errors++; $display("[TB] FAIL rand_char@%0d: got %h expected %h", i, char_out, modelQ[0]);
      end
      if (i % 7 == 0) begin
        loadStatus(s);
        checks++;
        if (s !== expStatus()) begin errors++; $display("[TB] FAIL rand_status@%0d: got %h expected %h", i, s, expStatus()); end
      end
    end
  endtask

  initial begin
    rst        = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    address    = '0;
    write_data = '0;
    char_ready = 1'b0;
    modelOvf   = 1'b0;
    modelDrops = 0;
    test_reset();
    test_single_push();
    test_stream();
    test_overflow();
    test_full_pushpop();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
